i2c_master_arbiter: RTL and testbench

I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

---
 rtl/i2c_master_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter
//
// Shares one I2C master command port between N_REQ requesters. A round-robin
// arbiter picks one requester while the master is idle and latches its
// command. The FSM then issues a one-cycle m_enable, follows the master's
// m_ready flag through busy and back to idle, and returns a one-cycle
// response. A cycle counter bounds each transaction and reports a timeout.
//
// Handshakes:
//   req_valid/req_ready : the requester holds valid and its fields stable
//                         until it sees its one-cycle req_ready pulse. A grant
//                         happens only in IDLE with m_ready=1. The arbiter
//                         does not need valid to drop after the grant.
//   rsp_valid           : one-cycle pulse with no backpressure. rsp_id,
//                         rsp_rdata and rsp_err hold until the next response.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   req_valid/addr/rw/wdata per-requester command inputs (packed)
//   req_ready               one-hot grant pulse
//   rsp_valid/id/rdata/err  completion response
//   m_address/rw/data_in/enable  command outputs to the I2C master
//   m_data_out, m_ready     read data and idle flag from the I2C master
//   busy                    high whenever the FSM is not in IDLE
//   dbg_state               current FSM state
// ---------------------------------------------------------------------------
module i2c_master_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [2:0]         rsp_id,
  output logic [7:0]         rsp_rdata,
  output logic               rsp_err,
  output logic [6:0]         m_address,
  output logic               m_rw,
  output logic [7:0]         m_data_in,
  output logic               m_enable,
  input  logic [7:0]         m_data_out,
  input  logic               m_ready,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [2:0]    id_q, id_d;
  logic [2:0]    rsp_id_q, rsp_id_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic          grant;
  logic [2:0]    winner;
  logic          found_hi;
  logic [2:0]    win_hi;
  logic [2:0]    win_lo;

  // Round-robin: the lowest valid index at or above ptr wins; if none, the
  // lowest valid index below ptr (the wrap). The descending scan keeps the
  // lowest match in each half.
  always_comb begin
    found_hi = 1'b0;
    win_hi   = 3'd0;
    win_lo   = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (3'(i) >= ptr_q) begin
          found_hi = 1'b1;
          win_hi   = 3'(i);
        end else begin
          win_lo = 3'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  // rst_n gates the grant so req_ready stays low while reset is held.
  assign grant     = rst_n && (state_q == S_IDLE) && m_ready && (|req_valid);
  assign req_ready = grant ? (N_REQ'(1) << winner) : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (winner == 3'(i)) begin
              addr_d  = req_addr[i*7 +: 7];
              rw_d    = req_rw[i];
              wdata_d = req_wdata[i*8 +: 8];
            end
          end
          id_d    = winner;
          ptr_d   = (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        cnt_d = cnt_q + CW'(1);
        // Timeout wins over a same-cycle m_ready change; the response then
        // lands exactly TIMEOUT cycles after ISSUE.
        if (cnt_d == CW'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          rsp_id_d    = id_q;
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b1;
        end else if ((state_q == S_WAIT_BUSY) && !m_ready) begin
          state_d = S_WAIT_DONE;
        end else if ((state_q == S_WAIT_DONE) && m_ready) begin
          state_d     = S_RESP;
          rsp_id_d    = id_q;
          rsp_rdata_d = rw_q ? m_data_out : 8'h00;
          rsp_err_d   = 1'b0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'd0;
      cnt_q       <= '0;
      addr_q      <= 7'd0;
      rw_q        <= 1'b0;
      wdata_q     <= 8'd0;
      id_q        <= 3'd0;
      rsp_id_q    <= 3'd0;
      rsp_rdata_q <= 8'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign m_enable  = (state_q == S_ISSUE);
  assign m_address = addr_q;
  assign m_rw      = rw_q;
  assign m_data_in = wdata_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_arbiter
//
// Directed bench for i2c_master_arbiter (N_REQ=2, TIMEOUT=64). The bench
// plays the I2C master by driving m_ready/m_data_out by hand. Inputs change
// 2 time units after a rising edge and outputs are sampled a further 1 unit
// later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_i2c_master_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [13:0] req_addr;
  logic [1:0]  req_rw;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [6:0]  m_address;
  logic        m_rw;
  logic [7:0]  m_data_in;
  logic        m_enable;
  logic [7:0]  m_data_out;
  logic        m_ready;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  i2c_master_arbiter #(.N_REQ(2), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_rw     (req_rw),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .m_address  (m_address),
    .m_rw       (m_rw),
    .m_data_in  (m_data_in),
    .m_enable   (m_enable),
    .m_data_out (m_data_out),
    .m_ready    (m_ready),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic [6:0] addr, input logic rw,
                         input logic [7:0] wd);
    req_addr[id*7 +: 7]  = addr;
    req_rw[id]           = rw;
    req_wdata[id*8 +: 8] = wd;
  endtask

  // Full transaction starting in an IDLE cycle with m_ready=1. The master
  // drops ready two cycles after enable and raises it wait_cycles later.
  task automatic do_txn(input int id, input logic [6:0] addr, input logic rw,
                        input logic [7:0] wd, input logic [7:0] mdo,
                        input int wait_cycles);
    logic [1:0] oh;
    oh = 2'(1 << id);
    set_req(id, addr, rw, wd);
    req_valid = oh;
    #1;
    check("grant_ready", 32'(req_ready), 32'(oh));
    check("grant_no_enable", 32'(m_enable), 32'd0);
    tick();
    req_valid = 2'b00;
    check("issue_enable", 32'(m_enable), 32'd1);
    check("issue_addr", 32'(m_address), 32'(addr));
    check("issue_rw", 32'(m_rw), 32'(rw));
    check("issue_wdata", 32'(m_data_in), 32'(wd));
    tick();
    check("wait_enable_low", 32'(m_enable), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    tick();
    m_ready    = 1'b0;
    m_data_out = mdo;
    repeat (wait_cycles) tick();
    check("wait_no_rsp", 32'(rsp_valid), 32'd0);
    check("addr_stable", 32'(m_address), 32'(addr));
    m_ready = 1'b1;
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_rdata", 32'(rsp_rdata), rw ? 32'(mdo) : 32'd0);
    check("rsp_err", 32'(rsp_err), 32'd0);
    tick();
    check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("rsp_id_hold", 32'(rsp_id), 32'(id));
  endtask

  initial begin
    rst_n      = 1'b1;
    req_valid  = 2'b00;
    req_addr   = '0;
    req_rw     = '0;
    req_wdata  = '0;
    m_data_out = 8'h00;
    m_ready    = 1'b1;

    // Reset state, with requests and m_ready present to show no grant.
    #1 rst_n = 1'b0;
    req_valid = 2'b11;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_m_enable", 32'(m_enable), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_address", 32'(m_address), 32'd0);
    check("rst_m_rw", 32'(m_rw), 32'd0);
    check("rst_m_data_in", 32'(m_data_in), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    tick();
    check("rst_hold_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

    // Single write from requester 0.
    do_txn(0, 7'h50, 1'b0, 8'hA5, 8'hEE, 20);

    // Single read from requester 1.
    do_txn(1, 7'h3C, 1'b1, 8'h00, 8'h5A, 4);

    // Contention: both held valid for four transactions -> 0,1,0,1.
    set_req(0, 7'h11, 1'b0, 8'h10);
    set_req(1, 7'h22, 1'b0, 8'h20);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check("rr_ready_single", 32'(req_ready), 32'd0);
      check("rr_addr", 32'(m_address), (k % 2 == 0) ? 32'h11 : 32'h22);
      tick();
      m_ready = 1'b0;
      tick();
      m_ready = 1'b1;
      tick();
      check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rr_rsp_id", 32'(rsp_id), 32'(k % 2));
      tick();
    end
    req_valid = 2'b00;

    // Timeout: read from requester 0, master never drops ready.
    set_req(0, 7'h2A, 1'b1, 8'h00);
    m_data_out = 8'h77;
    req_valid  = 2'b01;
    #1;
    check("to_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    check("to_issue", 32'(m_enable), 32'd1);
    repeat (62) tick();
    tick();
    check("to_not_yet", 32'(rsp_valid), 32'd0);
    check("to_busy", 32'(busy), 32'd1);
    tick();
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("to_rsp_id", 32'(rsp_id), 32'd0);
    tick();
    check("to_idle", 32'(busy), 32'd0);
    check("to_err_hold", 32'(rsp_err), 32'd1);

    // Gating: requester 1 valid while the master is busy for 10 cycles.
    m_ready = 1'b0;
    set_req(1, 7'h61, 1'b1, 8'h00);
    req_valid = 2'b10;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("gate_no_ready", 32'(req_ready), 32'd0);
      check("gate_no_enable", 32'(m_enable), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    do_txn(1, 7'h61, 1'b1, 8'h00, 8'h99, 3);

    // Reset during WAIT_DONE aborts with no response.
    set_req(0, 7'h33, 1'b1, 8'hC3);
    req_valid = 2'b01;
    #1;
    check("ab_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    m_ready = 1'b0;
    tick();
    tick();
    check("ab_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_m_address", 32'(m_address), 32'd0);
    check("ab_m_rw", 32'(m_rw), 32'd0);
    check("ab_m_data_in", 32'(m_data_in), 32'd0);
    check("ab_rsp_id", 32'(rsp_id), 32'd0);
    check("ab_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("ab_rsp_err", 32'(rsp_err), 32'd0);
    check("ab_rsp_valid", 32'(rsp_valid), 32'd0);
    m_ready   = 1'b1;
    req_valid = 2'b01;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("ab_hold_rsp", 32'(rsp_valid), 32'd0);
      check("ab_hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();
    check("ab_after_no_rsp", 32'(rsp_valid), 32'd0);

    // Next request completes normally.
    do_txn(0, 7'h44, 1'b0, 8'h5C, 8'h00, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
